// File: rtl/uart_tx_if.sv
// uart_tx byte-push bus and status/serial outputs.
// Master is the RAM write path; slave is the transmitter.
interface uart_tx_if;
  logic       write_enable;
  logic [7:0] data_in;
  logic       full;
  logic       idle;
  logic       overflow;
  logic       uart_tx_wire;

  modport master (
    output write_enable,
    output data_in,
    input  full,
    input  idle,
    input  overflow,
    input  uart_tx_wire
  );

  modport slave (
    input  write_enable,
    input  data_in,
    output full,
    output idle,
    output overflow,
    output uart_tx_wire
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_PARITY_EN to add an even-parity bit (8E1).
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [15:0]   RELOAD  = 16'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          idle_q, idle_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, empty;
  logic [7:0]    head;

  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tick;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign empty = (count_q == '0);
  assign push  = bus.write_enable & ~full_q;
  assign head  = mem_q[rd_ptr_q];
  assign tick  = (baud_q == '0);

  assign bus.full         = full_q;
  assign bus.idle         = idle_q;
  assign bus.overflow     = ovf_q;
  assign bus.uart_tx_wire = tx_q;

  // FIFO storage; contents are don't-care while pointers say empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // FIFO pointers, occupancy and registered status flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.write_enable & full_q);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
    idle_d = (state_d == S_IDLE) && (count_d == '0);
  end

  // Frame sequencer: next state, baud counter, shifter, line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE && !tick) baud_d = baud_q - 16'd1;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = RELOAD;
          shift_d = head;
          tx_d    = 1'b0;
`ifdef UART_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          baud_d  = RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_d = RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          baud_d  = RELOAD;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
            baud_d  = RELOAD;
            shift_d = head;
            tx_d    = 1'b0;
`ifdef UART_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      idle_q   <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + random pushes checked cycle by cycle
// against a queue/arithmetic model of the serial frames.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if u_if ();

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  int checks = 0;
  int passes = 0;
  string phase = "init";

  logic [7:0] mq [$];
  bit         fr_on = 1'b0;
  int         fr_start = 0;
  logic [7:0] fr_byte = 8'h00;
  int         cyc = 0;
  bit         m_ovf = 1'b0;

  logic exp_line, exp_idle, exp_full, exp_ovf;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_outputs();
    exp_line = fr_on ? frame_bit(fr_byte, (cyc - fr_start) / CPB) : 1'b1;
    exp_idle = !fr_on && (mq.size() == 0);
    exp_full = (mq.size() == DEPTH);
    exp_ovf  = m_ovf;
  endtask

  task automatic model_reset();
    mq.delete();
    fr_on = 1'b0;
    m_ovf = 1'b0;
    model_outputs();
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d);
    bit was_full;
    bit free;
    cyc++;
    was_full = (mq.size() == DEPTH);
    free = !fr_on || ((cyc - fr_start) >= NB * CPB);
    if (free) begin
      if (mq.size() > 0) begin
        fr_byte  = mq.pop_front();
        fr_start = cyc;
        fr_on    = 1'b1;
      end else begin
        fr_on = 1'b0;
      end
    end
    if (we) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(d);
    end
    model_outputs();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s/%s cyc=%0d observed=%b expected=%b",
                phase, tag, cyc, obs, exp);
  endtask

  task automatic check_all();
    chk("uart_tx_wire", u_if.uart_tx_wire, exp_line);
    chk("idle", u_if.idle, exp_idle);
    chk("full", u_if.full, exp_full);
    chk("overflow", u_if.overflow, exp_ovf);
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    u_if.write_enable = we;
    u_if.data_in      = d;
    @(posedge clk);
    model_edge(we, d);
    #1;
    u_if.write_enable = 1'b0;
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  logic [7:0] ba, bb, bc;

  initial begin
    u_if.write_enable = 1'b0;
    u_if.data_in      = 8'h00;

    phase = "reset";
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    phase = "single";
    step(1'b1, 8'h55);
    idle_steps(45);

    phase = "burst";
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h80);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h99);
    idle_steps(5 * NB * CPB + 8);

    phase = "pushpop";
    ba = 8'($urandom);
    bb = 8'($urandom);
    bc = 8'($urandom);
    step(1'b1, ba);
    step(1'b0, 8'h00);
    step(1'b1, bb);
    idle_steps(NB * CPB - 2);
    step(1'b1, bc);
    idle_steps(2 * NB * CPB + 8);

    phase = "midreset";
    step(1'b1, 8'h0F);
    idle_steps(18);
    async_reset();
    step(1'b1, 8'h81);
    idle_steps(NB * CPB + 6);

    phase = "parity";
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    idle_steps(2 * NB * CPB + 6);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 8'($urandom));
    end
    idle_steps(DEPTH * NB * CPB + NB * CPB + 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Memory-mapped serial transmitter that consumes byte writes to the UART address in the RAM block and drives the `uart_tx_wire` pin of the CPU top level. Stored bytes go into a small FIFO so that a burst of `SB`/`SW` stores from the CPU does not stall. A baud-rate FSM then serialises the bytes as 8N1 frames, LSB first. It sits directly downstream of the RAM write path. The RAM decodes the UART address and presents `write_enable`/`data_in` to this block.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit. Legal range is 2..65535.
- `FIFO_DEPTH`, default 4: byte FIFO entries. Must be a power of two, ≥2.
- `clk`  in  1  system clock. All state changes on its rising edge.
- `rst`  in  1  reset: asynchronous, active-high. Clears all state immediately.
- `write_enable`  in  1  one-cycle byte push request from the RAM address decoder.
- `data_in`  in  8  byte to transmit. Sampled when `write_enable`=1.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries. Registered. Reset 0.
- `idle`  out  1  FIFO empty and FSM in IDLE. Registered. Reset 1.
- `overflow`  out  1  sticky: a push was dropped because the FIFO was full. Cleared only by `rst`. Reset 0.
- `uart_tx_wire`  out  1  serial line, driven from a flop. Reset 1 (mark).

## Operation
- **FIFO**
  - Circular buffer with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally.
  - `count` is one bit wider than the pointers.
  - A push is accepted iff `write_enable`=1 and `full`=0 at the sampling edge. Otherwise the byte is discarded and `overflow` is set to 1.
  - A pop at the same edge as a push to a full FIFO does not rescue the push.
  - Push and pop at the same edge on a non-full FIFO: `count` stays unchanged and both pointers advance.
- **FSM states:** IDLE, START, DATA, PARITY (only when `UART_PARITY_EN` is defined), STOP.
  - IDLE → START when the FIFO is non-empty. That edge pops the head into `shift_reg[7:0]` and loads `baud_cnt`=`CLKS_PER_BIT`-1.
  - Any non-IDLE state counts `baud_cnt` down to 0. The transition happens at the edge where `baud_cnt`==0, which reloads `CLKS_PER_BIT`-1.
  - START → DATA. DATA shifts `shift_reg` right once per bit and uses `bit_idx` 0..7. DATA → PARITY or STOP after bit 7.
  - PARITY → STOP.
  - STOP → START with an immediate pop if the FIFO is non-empty (back-to-back, no idle gap). Otherwise STOP → IDLE.
- **Line drive:** IDLE = 1, START = 0, DATA = `shift_reg[0]`, PARITY = even parity of the byte, STOP = 1. `uart_tx_wire` is registered and updated at the same edge as the state change.
- **`idle`** is set to 1 at the edge the FSM enters IDLE with the FIFO empty and no push accepted. It is cleared at the edge a push is accepted.
- **Reset mid-frame:** the frame is aborted, the line returns to 1 asynchronously, FIFO contents are lost, and `overflow` is cleared.

## Timing
- A push accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - Pop at E1, where `uart_tx_wire` falls to 0.
  - Start bit is held for exactly `CLKS_PER_BIT` cycles: E1..E1+`CLKS_PER_BIT`.
  - Data bit k starts at E1+(k+1)·`CLKS_PER_BIT`.
- Frame length is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Back-to-back frames have exactly one stop bit between them.
- `full` rises at the edge of the push that makes `count`==`FIFO_DEPTH`. It falls at the next pop edge.
- `full` and `idle` have no combinational path from `write_enable`.
- Throughput: one byte per frame time. The FIFO absorbs bursts of up to `FIFO_DEPTH`+1 bytes, because the head byte leaves the FIFO one cycle after its push.

## Configuration
- **`UART_PARITY_EN` defined:**
  - The PARITY state is compiled in.
  - An even-parity bit (XOR of the 8 data bits) is sent between bit 7 and the stop bit.
  - Frame is 11 bits.
- **`UART_PARITY_EN` undefined:**
  - No PARITY state and no parity logic.
  - DATA → STOP directly, giving an 8N1 10-bit frame.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

1. **Reset values:** assert `rst` asynchronously mid-cycle → `uart_tx_wire`=1, `idle`=1, `full`=0, `overflow`=0 immediately, before any clock edge.
2. **Single byte:** push 0x55 → line 0 for 4 cycles starting one edge after the push. Then bits 1,0,1,0,1,0,1,0 at 4 cycles each. Then stop 1. `idle`=1 after 40 cycles.
3. **Burst:** push 0xA5, 0x01, 0xFF, 0x80, 0x3C on 5 consecutive cycles → all five frames appear back-to-back with no idle gap, and `overflow` stays 0. Push a 6th byte while `full`=1 → it is dropped and `overflow`=1.
4. **Simultaneous push and pop:** push at the exact edge where STOP completes and a queued byte is popped → `count` is unchanged and the byte order is preserved.
5. **Reset mid-frame:** pulse `rst` during data bit 3 of 0x0F → line is 1 at once. A following push of 0x81 gives a clean frame.
6. **Parity, with `UART_PARITY_EN`:**
   - 0x07 → parity bit 1.
   - 0x03 → parity bit 0.
   - Frame is 44 cycles.
